microcode_sequencer: RTL and testbench

Parametrised, writable microcode store plus stage sequencer for the multicycle core. It replaces the fixed {inst,stage} ROM by holding the stage register itself and following per-word next-stage/last fields, so instruction classes may skip stages. It also supports stall masking, illegal-word detection, a per-instruction step watchdog and a retired-instruction counter. It sits between the instruction decoder (class input) and the datapath control bus.

---
 rtl/microcode_pkg.sv | 44 ++++
 rtl/microcode_sequencer_if.sv | 38 +++
 rtl/microcode_store.sv | 24 ++
 rtl/microcode_sequencer.sv | 143 ++++++++++++++
 tb/tb_microcode_sequencer.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/microcode_pkg.sv
// Shared types and constants for the microcode sequencer: word layout, halt causes,
// sequencer states and the default write-enable mask.
package microcode_pkg;

   localparam int DEF_CWIDTH  = 24;
   localparam int DEF_CLASS_W = 5;
   localparam int DEF_STAGE_W = 3;
   localparam int DEF_CNT_W   = 32;

   // PC_WE, IR_WE, RF_WE and D_MEM_WEN live in these bits of the default control word.
   localparam logic [DEF_CWIDTH-1:0] DEF_WE_MASK = 24'hE00010;

   // Word layout is {valid, last, next_stage, ctrl}; offsets for the default widths.
   localparam int NEXT_LSB  = DEF_CWIDTH;
   localparam int LAST_BIT  = DEF_CWIDTH + DEF_STAGE_W;
   localparam int VALID_BIT = DEF_CWIDTH + DEF_STAGE_W + 1;

   localparam logic [1:0] HC_NONE    = 2'd0;
   localparam logic [1:0] HC_INVALID = 2'd1;
   localparam logic [1:0] HC_TIMEOUT = 2'd2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } uc_state_e;

   function automatic int word_width(input int cwidth, input int stage_w);
      return cwidth + stage_w + 2;
   endfunction

   function automatic int next_lsb(input int cwidth);
      return cwidth;
   endfunction

   function automatic int last_bit(input int cwidth, input int stage_w);
      return cwidth + stage_w;
   endfunction

   function automatic int valid_bit(input int cwidth, input int stage_w);
      return cwidth + stage_w + 1;
   endfunction

endpackage

// File: rtl/microcode_sequencer_if.sv
// Bus between decoder/loader (master) and the microcode sequencer (slave), plus
// a debug view of the sequencer state.
interface microcode_sequencer_if
   import microcode_pkg::*;
#(
   parameter int CWIDTH  = DEF_CWIDTH,
   parameter int CLASS_W = DEF_CLASS_W,
   parameter int STAGE_W = DEF_STAGE_W,
   parameter int CNT_W   = DEF_CNT_W
);
   // Handshake: start_i is a level request acted on only in IDLE; uc_we_i is a
   // per-cycle write strobe taken at the rising edge only in IDLE; done_o is a
   // one-cycle pulse in the cycle whose word retires the instruction.
   logic                         start_i;
   logic [CLASS_W-1:0]           class_i;
   logic                         stall_i;
   logic                         uc_we_i;
   logic [CLASS_W+STAGE_W-1:0]   uc_addr_i;
   logic [CWIDTH+STAGE_W+1:0]    uc_wdata_i;
   logic [CWIDTH-1:0]            ctrl_o;
   logic [STAGE_W-1:0]           stage_o;
   logic                         done_o;
   logic                         halted_o;
   logic [1:0]                   halt_cause_o;
   logic [CNT_W-1:0]             retired_o;
   uc_state_e                    dbg_state_o;

   modport master (
      output start_i, class_i, stall_i, uc_we_i, uc_addr_i, uc_wdata_i,
      input  ctrl_o, stage_o, done_o, halted_o, halt_cause_o, retired_o, dbg_state_o
   );

   modport slave (
      input  start_i, class_i, stall_i, uc_we_i, uc_addr_i, uc_wdata_i,
      output ctrl_o, stage_o, done_o, halted_o, halt_cause_o, retired_o, dbg_state_o
   );

endinterface

// File: rtl/microcode_store.sv
// Writable microcode RAM: synchronous write, asynchronous read, contents not reset.
module microcode_store #(
   parameter int AW = 8,
   parameter int DW = 29
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [DW-1:0] rdata_o
);

   logic [DW-1:0] mem_q [2**AW];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/microcode_sequencer.sv
// Stage sequencer over a writable microcode store: follows per-word next/last fields,
// masks write enables on stall, halts on invalid words or step timeout, counts retires.
module microcode_sequencer
   import microcode_pkg::*;
#(
   parameter int                CWIDTH    = DEF_CWIDTH,
   parameter int                CLASS_W   = DEF_CLASS_W,
   parameter int                STAGE_W   = DEF_STAGE_W,
   parameter logic [CWIDTH-1:0] WE_MASK   = CWIDTH'(DEF_WE_MASK),
   parameter int                MAX_STEPS = 8,
   parameter int                CNT_W     = DEF_CNT_W
) (
   input logic                  CLK,
   input logic                  RSTn,
   microcode_sequencer_if.slave bus
);

   localparam int AW     = CLASS_W + STAGE_W;
   localparam int WW     = word_width(CWIDTH, STAGE_W);
   localparam int V_BIT  = valid_bit(CWIDTH, STAGE_W);
   localparam int L_BIT  = last_bit(CWIDTH, STAGE_W);
   localparam int N_LSB  = next_lsb(CWIDTH);
   localparam int STEP_W = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1;

   uc_state_e          state_q, state_d;
   logic [STAGE_W-1:0] stage_q, stage_d;
   logic [CLASS_W-1:0] class_q, class_d;
   logic [STEP_W-1:0]  step_q, step_d;
   logic [CNT_W-1:0]   retired_q, retired_d;
   logic [1:0]         cause_q, cause_d;

   logic [AW-1:0]      rd_addr;
   logic [WW-1:0]      rd_word;
   logic               store_we;
   logic               w_valid;
   logic               w_last;
   logic [STAGE_W-1:0] w_next;
   logic [CWIDTH-1:0]  w_ctrl;
   logic [CWIDTH-1:0]  ctrl_c;
   logic               done_c;

   // Stage 0 reads with the live class so the first word needs no extra cycle.
   assign rd_addr  = (stage_q == '0) ? {bus.class_i, {STAGE_W{1'b0}}} : {class_q, stage_q};
   assign store_we = bus.uc_we_i && (state_q == IDLE);

   microcode_store #(
      .AW (AW),
      .DW (WW)
   ) u_store (
      .clk_i   (CLK),
      .we_i    (store_we),
      .waddr_i (bus.uc_addr_i),
      .wdata_i (bus.uc_wdata_i),
      .raddr_i (rd_addr),
      .rdata_o (rd_word)
   );

   assign w_valid = rd_word[V_BIT];
   assign w_last  = rd_word[L_BIT];
   assign w_next  = rd_word[N_LSB +: STAGE_W];
   assign w_ctrl  = rd_word[CWIDTH-1:0];

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q   <= IDLE;
         stage_q   <= '0;
         class_q   <= '0;
         step_q    <= '0;
         retired_q <= '0;
         cause_q   <= HC_NONE;
      end else begin
         state_q   <= state_d;
         stage_q   <= stage_d;
         class_q   <= class_d;
         step_q    <= step_d;
         retired_q <= retired_d;
         cause_q   <= cause_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      stage_d   = stage_q;
      class_d   = class_q;
      step_d    = step_q;
      retired_d = retired_q;
      cause_d   = cause_q;
      ctrl_c    = '0;
      done_c    = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start_i) begin
               state_d = RUN;
               stage_d = '0;
               step_d  = '0;
            end
         end
         RUN: begin
            if (bus.stall_i) begin
               ctrl_c = w_ctrl & ~WE_MASK;
            end else begin
               if (stage_q == '0) begin
                  class_d = bus.class_i;
               end
               if (!w_valid) begin
                  state_d = HALT;
                  cause_d = HC_INVALID;
               end else if (w_last) begin
                  ctrl_c    = w_ctrl;
                  done_c    = 1'b1;
                  stage_d   = '0;
                  step_d    = '0;
                  retired_d = retired_q + CNT_W'(1);
               end else if (step_q == STEP_W'(MAX_STEPS - 1)) begin
                  // The timed-out word still drives its control this cycle.
                  ctrl_c  = w_ctrl;
                  state_d = HALT;
                  cause_d = HC_TIMEOUT;
               end else begin
                  ctrl_c  = w_ctrl;
                  stage_d = w_next;
                  step_d  = step_q + STEP_W'(1);
               end
            end
         end
         HALT: begin
            state_d = HALT;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.ctrl_o       = ctrl_c;
   assign bus.stage_o      = stage_q;
   assign bus.done_o       = done_c;
   assign bus.halted_o     = (state_q == HALT);
   assign bus.halt_cause_o = cause_q;
   assign bus.retired_o    = retired_q;
   assign bus.dbg_state_o  = state_q;

endmodule

// File: tb/tb_microcode_sequencer.sv
// Directed bench for microcode_sequencer: per-cycle vector table plus hand-written
// reset/restart sequence.
module tb_microcode_sequencer;
   import microcode_pkg::*;

   localparam int CW   = 24;
   localparam int CLW  = 5;
   localparam int SW   = 3;
   localparam int WW   = CW + SW + 2;
   localparam int CNTW = 32;

   localparam logic [CW-1:0] C0_S0  = 24'hCC0787;
   localparam logic [CW-1:0] C0_S1  = 24'h000787;
   localparam logic [CW-1:0] C0_S2  = 24'h018787;
   localparam logic [CW-1:0] C0_S4  = 24'h200787;
   localparam logic [CW-1:0] C26_S0 = 24'h400123;
   localparam logic [CW-1:0] C26_S4 = 24'h800456;
   localparam logic [CW-1:0] C5_S0  = 24'h000111;
   localparam logic [CW-1:0] C5_S5  = 24'h000232;
   localparam logic [CW-1:0] C31_S0 = 24'hFFFFFF;

   typedef struct {
      logic            start;
      logic [CLW-1:0]  cls;
      logic            stall;
      logic            we;
      logic [CLW+SW-1:0] waddr;
      logic [WW-1:0]   wdata;
      logic [CW-1:0]   e_ctrl;
      logic [SW-1:0]   e_stage;
      logic            e_done;
      logic            e_halted;
      logic [1:0]      e_cause;
      logic [CNTW-1:0] e_ret;
   } vec_t;

   logic CLK = 1'b0;
   logic RSTn = 1'b0;
   int   checks = 0;
   int   errors = 0;
   vec_t tv[$];
   logic [CW-1:0] exp_q[$];

   microcode_sequencer_if #(.CWIDTH(CW), .CLASS_W(CLW), .STAGE_W(SW), .CNT_W(CNTW)) bus ();

   microcode_sequencer #(
      .CWIDTH    (CW),
      .CLASS_W   (CLW),
      .STAGE_W   (SW),
      .WE_MASK   (24'hE00010),
      .MAX_STEPS (8),
      .CNT_W     (CNTW)
   ) dut (
      .CLK  (CLK),
      .RSTn (RSTn),
      .bus  (bus)
   );

   always #5 CLK = ~CLK;

   function automatic logic [WW-1:0] mkw(input logic v, input logic l, input logic [SW-1:0] nx,
                                         input logic [CW-1:0] c);
      return {v, l, nx, c};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic st, input logic [CLW-1:0] cls, input logic stall,
                      input logic we, input logic [CLW+SW-1:0] wa, input logic [WW-1:0] wd,
                      input logic [CW-1:0] ctrl, input logic [SW-1:0] stage, input logic done,
                      input logic halted, input logic [1:0] cause, input logic [CNTW-1:0] ret);
      vec_t v;
      v.start = st;  v.cls = cls;  v.stall = stall;  v.we = we;  v.waddr = wa;  v.wdata = wd;
      v.e_ctrl = ctrl;  v.e_stage = stage;  v.e_done = done;  v.e_halted = halted;
      v.e_cause = cause;  v.e_ret = ret;
      tv.push_back(v);
   endtask

   task automatic idle_inputs();
      bus.start_i    = 1'b0;
      bus.class_i    = '0;
      bus.stall_i    = 1'b0;
      bus.uc_we_i    = 1'b0;
      bus.uc_addr_i  = '0;
      bus.uc_wdata_i = '0;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, " ctrl"},    32'(bus.ctrl_o), 32'h0);
      chk({tag, " stage"},   32'(bus.stage_o), 32'h0);
      chk({tag, " done"},    32'(bus.done_o), 32'h0);
      chk({tag, " halted"},  32'(bus.halted_o), 32'h0);
      chk({tag, " cause"},   32'(bus.halt_cause_o), 32'h0);
      chk({tag, " retired"}, bus.retired_o, 32'h0);
   endtask

   task automatic do_reset(input string tag);
      @(negedge CLK);
      RSTn = 1'b0;
      idle_inputs();
      @(negedge CLK);
      #1;
      check_zero(tag);
      @(negedge CLK);
      RSTn = 1'b1;
   endtask

   task automatic load(input logic [CLW-1:0] cls, input logic [SW-1:0] st, input logic [WW-1:0] w);
      @(negedge CLK);
      bus.uc_we_i    = 1'b1;
      bus.uc_addr_i  = {cls, st};
      bus.uc_wdata_i = w;
      @(negedge CLK);
      bus.uc_we_i    = 1'b0;
   endtask

   task automatic run_rows(input int first, input int last);
      for (int i = first; i <= last; i++) begin
         @(negedge CLK);
         bus.start_i    = tv[i].start;
         bus.class_i    = tv[i].cls;
         bus.stall_i    = tv[i].stall;
         bus.uc_we_i    = tv[i].we;
         bus.uc_addr_i  = tv[i].waddr;
         bus.uc_wdata_i = tv[i].wdata;
         #1;
         chk($sformatf("row%0d ctrl", i),    32'(bus.ctrl_o), 32'(tv[i].e_ctrl));
         chk($sformatf("row%0d stage", i),   32'(bus.stage_o), 32'(tv[i].e_stage));
         chk($sformatf("row%0d done", i),    32'(bus.done_o), 32'(tv[i].e_done));
         chk($sformatf("row%0d halted", i),  32'(bus.halted_o), 32'(tv[i].e_halted));
         chk($sformatf("row%0d cause", i),   32'(bus.halt_cause_o), 32'(tv[i].e_cause));
         chk($sformatf("row%0d retired", i), bus.retired_o, tv[i].e_ret);
      end
   endtask

   initial begin
      int a_end, b_end, c_end;
      idle_inputs();

      // Segment A: sequencing, stalls, skipping class, start-in-RUN, watchdog.
      add(1, 0,  0, 0, 0, 0, 24'h0,    0, 0, 0, 0, 0);
      add(0, 0,  0, 0, 0, 0, C0_S0,    0, 0, 0, 0, 0);
      add(0, 0,  0, 0, 0, 0, C0_S1,    1, 0, 0, 0, 0);
      add(0, 0,  0, 0, 0, 0, C0_S2,    2, 0, 0, 0, 0);
      add(0, 0,  0, 0, 0, 0, C0_S4,    4, 1, 0, 0, 0);
      add(0, 0,  0, 0, 0, 0, C0_S0,    0, 0, 0, 0, 1);
      add(0, 0,  0, 0, 0, 0, C0_S1,    1, 0, 0, 0, 1);
      add(0, 0,  1, 0, 0, 0, 24'h018787, 2, 0, 0, 0, 1);
      add(0, 0,  1, 0, 0, 0, 24'h018787, 2, 0, 0, 0, 1);
      add(0, 0,  1, 0, 0, 0, 24'h018787, 2, 0, 0, 0, 1);
      add(0, 0,  0, 0, 0, 0, C0_S2,    2, 0, 0, 0, 1);
      add(0, 0,  0, 0, 0, 0, C0_S4,    4, 1, 0, 0, 1);
      add(0, 0,  1, 0, 0, 0, 24'h0C0787, 0, 0, 0, 0, 2);
      add(0, 0,  0, 0, 0, 0, C0_S0,    0, 0, 0, 0, 2);
      add(0, 0,  0, 0, 0, 0, C0_S1,    1, 0, 0, 0, 2);
      add(0, 0,  0, 0, 0, 0, C0_S2,    2, 0, 0, 0, 2);
      add(0, 0,  1, 0, 0, 0, 24'h000787, 4, 0, 0, 0, 2);
      add(0, 0,  0, 0, 0, 0, C0_S4,    4, 1, 0, 0, 2);
      add(0, 26, 0, 0, 0, 0, C26_S0,   0, 0, 0, 0, 3);
      add(0, 0,  0, 0, 0, 0, C26_S4,   4, 1, 0, 0, 3);
      add(0, 26, 0, 0, 0, 0, C26_S0,   0, 0, 0, 0, 4);
      add(0, 3,  0, 0, 0, 0, C26_S4,   4, 1, 0, 0, 4);
      add(1, 26, 0, 0, 0, 0, C26_S0,   0, 0, 0, 0, 5);
      add(1, 0,  0, 0, 0, 0, C26_S4,   4, 1, 0, 0, 5);
      add(0, 5,  0, 0, 0, 0, C5_S0,    0, 0, 0, 0, 6);
      add(0, 5,  0, 0, 0, 0, C5_S5,    5, 0, 0, 0, 6);
      add(0, 5,  0, 0, 0, 0, C5_S5,    5, 0, 0, 0, 6);
      add(0, 5,  0, 0, 0, 0, C5_S5,    5, 0, 0, 0, 6);
      add(0, 5,  1, 0, 0, 0, 24'h000222, 5, 0, 0, 0, 6);
      add(0, 5,  0, 0, 0, 0, C5_S5,    5, 0, 0, 0, 6);
      add(0, 5,  0, 0, 0, 0, C5_S5,    5, 0, 0, 0, 6);
      add(0, 5,  0, 0, 0, 0, C5_S5,    5, 0, 0, 0, 6);
      add(0, 5,  0, 0, 0, 0, C5_S5,    5, 0, 0, 0, 6);
      add(1, 0,  0, 0, 0, 0, 24'h0,    5, 0, 1, 2, 6);
      add(0, 0,  0, 0, 0, 0, 24'h0,    5, 0, 1, 2, 6);
      a_end = tv.size() - 1;
      // Segment B: stalled invalid word, invalid halt, start/write ignored in HALT.
      add(1, 31, 0, 0, 0, 0, 24'h0,      0, 0, 0, 0, 0);
      add(0, 31, 1, 0, 0, 0, 24'h1FFFEF, 0, 0, 0, 0, 0);
      add(0, 31, 0, 0, 0, 0, 24'h0,      0, 0, 0, 0, 0);
      add(1, 0,  0, 1, 8'h01, mkw(1, 1, 0, 24'hABCDEF), 24'h0, 0, 0, 1, 1, 0);
      add(0, 0,  0, 0, 0, 0, 24'h0,      0, 0, 1, 1, 0);
      b_end = tv.size() - 1;
      // Segment C: write attempt during RUN, then reset mid-instruction.
      add(1, 0,  0, 0, 0, 0, 24'h0,    0, 0, 0, 0, 0);
      add(0, 0,  0, 1, 8'h01, mkw(1, 1, 0, 24'h123456), C0_S0, 0, 0, 0, 0, 0);
      add(0, 0,  0, 0, 0, 0, C0_S1,    1, 0, 0, 0, 0);
      c_end = tv.size() - 1;

      do_reset("reset");
      load(0,  0, mkw(1, 0, 1, C0_S0));
      load(0,  1, mkw(1, 0, 2, C0_S1));
      load(0,  2, mkw(1, 0, 4, C0_S2));
      load(0,  4, mkw(1, 1, 0, C0_S4));
      load(26, 0, mkw(1, 0, 4, C26_S0));
      load(26, 4, mkw(1, 1, 0, C26_S4));
      load(31, 0, mkw(0, 0, 0, C31_S0));
      load(5,  0, mkw(1, 0, 5, C5_S0));
      load(5,  5, mkw(1, 0, 5, C5_S5));
      run_rows(0, a_end);

      do_reset("reset_b");
      run_rows(a_end + 1, b_end);

      do_reset("reset_c");
      run_rows(b_end + 1, c_end);

      // Reset lands while the instruction sits at stage 2.
      @(negedge CLK);
      RSTn = 1'b0;
      idle_inputs();
      #1;
      check_zero("mid_reset");
      chk("mid_reset state", 32'(bus.dbg_state_o), 32'(IDLE));
      @(negedge CLK);
      RSTn = 1'b1;

      // Restart from the retained store; dropped writes must not be visible.
      exp_q.push_back(C0_S0);
      exp_q.push_back(C0_S1);
      exp_q.push_back(C0_S2);
      exp_q.push_back(C0_S4);
      @(negedge CLK);
      bus.start_i = 1'b1;
      bus.class_i = '0;
      #1;
      chk("restart idle ctrl", 32'(bus.ctrl_o), 32'h0);
      for (int k = 0; k < 4; k++) begin
         logic [CW-1:0] e;
         @(negedge CLK);
         bus.start_i = 1'b0;
         #1;
         e = exp_q.pop_front();
         chk($sformatf("restart ctrl%0d", k), 32'(bus.ctrl_o), 32'(e));
         chk($sformatf("restart done%0d", k), 32'(bus.done_o), (k == 3) ? 32'h1 : 32'h0);
      end
      @(negedge CLK);
      bus.class_i = 5'd26;
      #1;
      chk("restart retired", bus.retired_o, 32'h1);
      chk("restart next ctrl", 32'(bus.ctrl_o), 32'(C26_S0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
